tile_painter: RTL and testbench
===============================

// Module: tile_painter
// PURPOSE
//  Downstream of the grid scanner, which walks the 16x12 cells and flags changed cells with diff.
//  On each diff request, latches (x, y, obj_code) and paints one CELL_PX x CELL_PX tile.
//  Painting uses the 8-bit 8080-style ILI9341 LCD bus: CASET, PASET, RAMWR, then RGB565 pixels.
//  Returns a one-cycle cmd_done pulse, which the scanner waits on before moving to the next cell.
// PARAMETERS
//  CELL_PX  20  tile edge in pixels (16x20=320, 12x20=240)
//  COLS     16  grid columns; x range 0..COLS-1
//  ROWS     12  grid rows; y range 0..ROWS-1
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  nrst      in   1  reset, synchronous, active-low
//  start     in   1  paint request; connects to the scanner's diff
//  x         in   4  tile column
//  y         in   4  tile row
//  obj_code  in   3  tile content: 0 blank, 1 body, 2 head, 3 apple, 4 border; 5-7 treated as blank
//  cmd_done  out  1  one-cycle pulse when the tile is finished or rejected
//  busy      out  1  high from the cycle after acceptance through the cmd_done cycle
//  lcd_cs_n  out  1  chip select, active-low
//  lcd_dcx   out  1  0 = command byte, 1 = data byte
//  lcd_wr_n  out  1  write strobe; LCD latches on the rising edge
//  lcd_d     out  8  bus data
// BEHAVIOUR
//  Reset (nrst=0 at a posedge): next-cycle outputs are
//   cmd_done=0, busy=0, lcd_cs_n=1, lcd_dcx=1, lcd_wr_n=1, lcd_d=8'h00; FSM goes to IDLE.
//  Reset mid-paint aborts immediately; no cmd_done is issued for the aborted tile.
//  Acceptance: in IDLE, start=1 at a posedge latches x, y and obj_code.
//   start is ignored while busy; inputs may change freely after acceptance.
//  Byte timing: each byte takes 2 cycles, with wr_n=0 in cycle A and wr_n=1 in cycle B.
//   lcd_d and lcd_dcx are valid from cycle A through cycle B.
//   lcd_cs_n=0 from the first byte's A cycle through the last byte's B cycle.
//  Byte sequence:
//   - 2A cmd
//   - xs[15:8], xs[7:0], xe[15:8], xe[7:0]
//   - 2B cmd
//   - ys hi/lo, ye hi/lo
//   - 2C cmd
//   - CELL_PX^2 pixels, each sent colour[15:8] then colour[7:0]
//  Byte count: 11 + 2*CELL_PX^2 bytes (811 at default), so 1622 bus cycles.
//  cmd_done rises in the cycle after the last B cycle; acceptance to cmd_done is 1623 cycles.
//  Arithmetic, all 16-bit unsigned:
//   xs = x*CELL_PX, xe = xs+CELL_PX-1; ys = y*CELL_PX, ye = ys+CELL_PX-1.
//   Multiply done by constant-multiply logic, registered in the acceptance cycle.
//  Out of range: y>=ROWS or x>=COLS means no bus activity; cmd_done pulses 1 cycle after acceptance.
//  FSM states and transitions:
//   IDLE
//    -> C_CASET -> D_CASET (4 bytes) -> C_PASET -> D_PASET (4 bytes)
//    -> C_RAMWR -> PIXELS -> DONE -> IDLE
//   IDLE -> DONE directly on an out-of-range tile.
//  Counters:
//   - 2-bit param byte index
//   - 1-bit hi/lo pixel byte select
//   - $clog2(CELL_PX^2)-bit pixel count
//   - 1-bit strobe phase
//   All counters clear on reset and on entering each state.
//  start=1 in the DONE cycle is not accepted; it is accepted in the next IDLE cycle.
//  Back-to-back requests: acceptance is earliest 1 cycle after cmd_done.
// STRUCTURE
//  snake_pkg contents:
//   - obj_code_t enum (BLANK, BODY, HEAD, APPLE, BORDER)
//   - RGB565 colour constants: BLANK 16'h0000, BODY 16'h07E0, HEAD 16'h03E0, APPLE 16'hF800, BORDER 16'hFFFF
//   - LCD opcodes CASET 8'h2A, PASET 8'h2B, RAMWR 8'h2C
//   - colour_of(obj_code_t) function
//  Sub-module lcd_byte_writer: req/byte/dc in, ack out; owns wr_n phase, lcd_d and lcd_dcx.
//  tile_painter is the sequencing FSM above it.
// TESTING
//  1. Reset with start=0 -> all outputs at reset values; hold 100 cycles with no wr_n edges.
//  2. start with x=4, y=4, obj=2 -> captured bytes 2A 00 50 00 63 2B 00 50 00 63 2C, then 400x(03,E0);
//     cmd_done 1623 cycles after acceptance, exactly 1 cycle wide.
//  3. start with x=15, y=11, obj=4 -> xs/xe=300/319, ys/ye=220/239; all pixels FFFF.
//  4. start again at cycle 500 of a tile -> ignored; exactly 811 bytes on the bus and one cmd_done.
//  5. nrst low at pixel 200 -> cs_n=1 and wr_n=1 next cycle, no cmd_done;
//     a new start then paints a full 811-byte tile.
//  6. start with y=13 -> no wr_n low, cmd_done 1 cycle later; obj_code=7 paints 0000.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake tile painter: object codes, RGB565 colours,
// ILI9341 opcodes and the painter FSM state encoding.
package snake_pkg;

   typedef enum logic [2:0] {
      BLANK  = 3'd0,
      BODY   = 3'd1,
      HEAD   = 3'd2,
      APPLE  = 3'd3,
      BORDER = 3'd4
   } obj_code_t;

   localparam logic [15:0] COLOUR_BLANK  = 16'h0000;
   localparam logic [15:0] COLOUR_BODY   = 16'h07E0;
   localparam logic [15:0] COLOUR_HEAD   = 16'h03E0;
   localparam logic [15:0] COLOUR_APPLE  = 16'hF800;
   localparam logic [15:0] COLOUR_BORDER = 16'hFFFF;

   localparam logic [7:0] LCD_CASET = 8'h2A;
   localparam logic [7:0] LCD_PASET = 8'h2B;
   localparam logic [7:0] LCD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      IDLE,
      C_CASET,
      D_CASET,
      C_PASET,
      D_PASET,
      C_RAMWR,
      PIXELS,
      DONE
   } state_t;

   function automatic logic [15:0] colour_of(input obj_code_t obj);
      case (obj)
         BODY:    return COLOUR_BODY;
         HEAD:    return COLOUR_HEAD;
         APPLE:   return COLOUR_APPLE;
         BORDER:  return COLOUR_BORDER;
         default: return COLOUR_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Two-cycle 8080 byte strobe: cycle A drives wr_n low with the byte, cycle B raises it.
// A new byte is taken (ack) only while wr_n is high, so bytes stream back to back.
module lcd_byte_writer (
   input  logic       clk,
   input  logic       nrst,
   input  logic       i_req,
   input  logic [7:0] i_byte,
   input  logic       i_dc,
   output logic       o_ack,
   output logic       o_wr_n,
   output logic       o_dcx,
   output logic [7:0] o_d
);

   logic       r_wr_n;
   logic       r_dcx;
   logic [7:0] r_d;

   assign o_ack  = i_req & r_wr_n;
   assign o_wr_n = r_wr_n;
   assign o_dcx  = r_dcx;
   assign o_d    = r_d;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_wr_n <= 1'b1;
         r_dcx  <= 1'b1;
         r_d    <= 8'h00;
      end else if (!r_wr_n) begin
         r_wr_n <= 1'b1;
      end else if (i_req) begin
         r_wr_n <= 1'b0;
         r_dcx  <= i_dc;
         r_d    <= i_byte;
      end
   end

endmodule

// File: rtl/tile_painter.sv
// Paints one CELL_PX square tile on an ILI9341 over the 8-bit 8080 bus per accepted request.
// The state names the byte currently on the bus; the next byte is offered during its B cycle.
module tile_painter
   import snake_pkg::*;
#(
   parameter int unsigned CELL_PX = 20,
   parameter int unsigned COLS    = 16,
   parameter int unsigned ROWS    = 12
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [2:0] obj_code,
   output logic       cmd_done,
   output logic       busy,
   output logic       lcd_cs_n,
   output logic       lcd_dcx,
   output logic       lcd_wr_n,
   output logic [7:0] lcd_d
);

   localparam int unsigned NPIX = CELL_PX * CELL_PX;
   localparam int unsigned PW   = $clog2(NPIX);
   localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

   state_t         r_state;
   logic [1:0]     r_idx;
   logic           r_hilo;
   logic [PW-1:0]  r_pix;
   logic [15:0]    r_xs, r_xe, r_ys, r_ye, r_colour;
   logic           r_cmd_done, r_busy, r_cs_n;

   logic           w_in_range, w_last, w_req, w_dc, w_ack;
   logic [7:0]     w_byte;
   logic [15:0]    w_xs, w_ys;
   obj_code_t      w_obj;

   assign w_in_range = ({28'd0, x} < COLS) && ({28'd0, y} < ROWS);
   assign w_xs       = 16'(x) * 16'(CELL_PX);
   assign w_ys       = 16'(y) * 16'(CELL_PX);
   assign w_obj      = (obj_code > 3'd4) ? BLANK : obj_code_t'(obj_code);
   // Final low pixel byte is on the bus: nothing further to offer.
   assign w_last     = (r_state == PIXELS) && (r_pix == LAST_PIX) && r_hilo;

   assign cmd_done = r_cmd_done;
   assign busy     = r_busy;
   assign lcd_cs_n = r_cs_n;

   always_comb begin
      w_req  = 1'b1;
      w_dc   = 1'b1;
      w_byte = 8'h00;
      case (r_state)
         IDLE: begin
            w_req  = start & w_in_range;
            w_dc   = 1'b0;
            w_byte = LCD_CASET;
         end
         C_CASET: w_byte = r_xs[15:8];
         D_CASET: begin
            case (r_idx)
               2'd0:    w_byte = r_xs[7:0];
               2'd1:    w_byte = r_xe[15:8];
               2'd2:    w_byte = r_xe[7:0];
               default: begin
                  w_dc   = 1'b0;
                  w_byte = LCD_PASET;
               end
            endcase
         end
         C_PASET: w_byte = r_ys[15:8];
         D_PASET: begin
            case (r_idx)
               2'd0:    w_byte = r_ys[7:0];
               2'd1:    w_byte = r_ye[15:8];
               2'd2:    w_byte = r_ye[7:0];
               default: begin
                  w_dc   = 1'b0;
                  w_byte = LCD_RAMWR;
               end
            endcase
         end
         C_RAMWR: w_byte = r_colour[15:8];
         PIXELS: begin
            w_req  = !w_last;
            w_byte = r_hilo ? r_colour[15:8] : r_colour[7:0];
         end
         default: w_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state    <= IDLE;
         r_idx      <= 2'd0;
         r_hilo     <= 1'b0;
         r_pix      <= '0;
         r_xs       <= 16'h0000;
         r_xe       <= 16'h0000;
         r_ys       <= 16'h0000;
         r_ye       <= 16'h0000;
         r_colour   <= 16'h0000;
         r_cmd_done <= 1'b0;
         r_busy     <= 1'b0;
         r_cs_n     <= 1'b1;
      end else begin
         r_cmd_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_xs     <= w_xs;
                  r_xe     <= w_xs + 16'(CELL_PX - 1);
                  r_ys     <= w_ys;
                  r_ye     <= w_ys + 16'(CELL_PX - 1);
                  r_colour <= colour_of(w_obj);
                  r_busy   <= 1'b1;
                  r_idx    <= 2'd0;
                  r_hilo   <= 1'b0;
                  r_pix    <= '0;
                  if (w_in_range) begin
                     r_cs_n  <= 1'b0;
                     r_state <= C_CASET;
                  end else begin
                     r_cmd_done <= 1'b1;
                     r_state    <= DONE;
                  end
               end
            end
            C_CASET: if (w_ack) begin
               r_idx   <= 2'd0;
               r_state <= D_CASET;
            end
            D_CASET: if (w_ack) begin
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) r_state <= C_PASET;
            end
            C_PASET: if (w_ack) begin
               r_idx   <= 2'd0;
               r_state <= D_PASET;
            end
            D_PASET: if (w_ack) begin
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) r_state <= C_RAMWR;
            end
            C_RAMWR: if (w_ack) begin
               r_hilo  <= 1'b0;
               r_pix   <= '0;
               r_state <= PIXELS;
            end
            PIXELS: begin
               if (w_last) begin
                  if (lcd_wr_n) begin
                     r_hilo     <= 1'b0;
                     r_pix      <= '0;
                     r_cs_n     <= 1'b1;
                     r_cmd_done <= 1'b1;
                     r_state    <= DONE;
                  end
               end else if (w_ack) begin
                  r_hilo <= !r_hilo;
                  if (r_hilo) r_pix <= r_pix + PW'(1);
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   lcd_byte_writer u_writer (
      .clk    (clk),
      .nrst   (nrst),
      .i_req  (w_req),
      .i_byte (w_byte),
      .i_dc   (w_dc),
      .o_ack  (w_ack),
      .o_wr_n (lcd_wr_n),
      .o_dcx  (lcd_dcx),
      .o_d    (lcd_d)
   );

endmodule

// File: tb/tb_tile_painter.sv
// Self-checking bench for tile_painter: directed and random tiles against a byte-list model.
module tb_tile_painter;

   logic       clk = 1'b0;
   logic       nrst;
   logic       start;
   logic [3:0] x, y;
   logic [2:0] obj_code;
   logic       cmd_done, busy, lcd_cs_n, lcd_dcx, lcd_wr_n;
   logic [7:0] lcd_d;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int wrn_fall = 0;
   int cs_bad = 0;
   logic [8:0] cap_q[$];
   logic [8:0] exp_q[$];
   logic [15:0] colour_tab [8] = '{16'h0000, 16'h07E0, 16'h03E0, 16'hF800, 16'hFFFF,
                                   16'h0000, 16'h0000, 16'h0000};

   always #5 clk = ~clk;

   tile_painter dut (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .x        (x),
      .y        (y),
      .obj_code (obj_code),
      .cmd_done (cmd_done),
      .busy     (busy),
      .lcd_cs_n (lcd_cs_n),
      .lcd_dcx  (lcd_dcx),
      .lcd_wr_n (lcd_wr_n),
      .lcd_d    (lcd_d)
   );

   // The panel latches {dcx, data} on each wr_n rising edge.
   always @(posedge lcd_wr_n) begin
      cap_q.push_back({lcd_dcx, lcd_d});
      if (lcd_cs_n !== 1'b0) cs_bad++;
   end
   always @(negedge lcd_wr_n) wrn_fall++;
   always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back({1'b1, w[15:8]});
      exp_q.push_back({1'b1, w[7:0]});
   endtask

   task automatic build_model(input int tx, input int ty, input int tob);
      int xs, ys;
      exp_q.delete();
      if (tx >= 16 || ty >= 12) return;
      xs = tx * 20;
      ys = ty * 20;
      exp_q.push_back({1'b0, 8'h2A});
      push_word(16'(xs));
      push_word(16'(xs + 19));
      exp_q.push_back({1'b0, 8'h2B});
      push_word(16'(ys));
      push_word(16'(ys + 19));
      exp_q.push_back({1'b0, 8'h2C});
      for (int p = 0; p < 400; p++) push_word(colour_tab[tob]);
   endtask

   task automatic run_tile(input int tx, input int ty, input int tob,
                           input int poke_at, input int rst_at);
      int n, bad, done0, exp_lat;
      logic hit;
      build_model(tx, ty, tob);
      exp_lat = (exp_q.size() == 0) ? 1 : 1623;
      @(negedge clk);
      cap_q.delete();
      cs_bad   = 0;
      done0    = done_cnt;
      start    = 1'b1;
      x        = 4'(tx);
      y        = 4'(ty);
      obj_code = 3'(tob);
      n   = 0;
      hit = 1'b0;
      while (n < 3000 && !hit) begin
         @(negedge clk);
         n++;
         start = (n == poke_at);
         if (n == 1) begin
            x        = 4'($urandom);
            y        = 4'($urandom);
            obj_code = 3'($urandom);
         end
         if (n == rst_at) begin
            nrst = 1'b0;
            @(negedge clk);
            chk("abort_cs_n", {31'd0, lcd_cs_n}, 1);
            chk("abort_wr_n", {31'd0, lcd_wr_n}, 1);
            chk("abort_busy", {31'd0, busy}, 0);
            nrst = 1'b1;
            repeat (20) @(negedge clk);
            chk("abort_no_done", done_cnt - done0, 0);
            return;
         end
         if (cmd_done === 1'b1) hit = 1'b1;
      end
      chk("latency", n, exp_lat);
      chk("busy_at_done", {31'd0, busy}, 1);
      @(negedge clk);
      start = 1'b0;
      chk("done_width", {31'd0, cmd_done}, 0);
      chk("busy_after", {31'd0, busy}, 0);
      chk("byte_count", cap_q.size(), exp_q.size());
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         if (cap_q[i] !== exp_q[i]) bad++;
      chk("byte_mismatches", bad, 0);
      chk("cs_during_write", cs_bad, 0);
      chk("done_pulses", done_cnt - done0, 1);
   endtask

   initial begin
      int f0;
      nrst     = 1'b0;
      start    = 1'b0;
      x        = 4'd0;
      y        = 4'd0;
      obj_code = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_done", {31'd0, cmd_done}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_cs_n", {31'd0, lcd_cs_n}, 1);
      chk("rst_dcx", {31'd0, lcd_dcx}, 1);
      chk("rst_wr_n", {31'd0, lcd_wr_n}, 1);
      chk("rst_d", {24'd0, lcd_d}, 0);
      f0 = wrn_fall;
      nrst = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_no_wr", wrn_fall - f0, 0);
      chk("idle_cs_n", {31'd0, lcd_cs_n}, 1);

      run_tile(4, 4, 2, -1, -1);
      run_tile(15, 11, 4, -1, -1);
      run_tile(7, 3, 3, 500, -1);
      run_tile(2, 5, 1, -1, 819);
      run_tile(2, 5, 1, -1, -1);
      run_tile(3, 13, 1, 1, -1);
      run_tile(0, 12, 2, -1, -1);
      run_tile(5, 5, 7, -1, -1);
      run_tile(0, 0, 3, 1623, -1);
      for (int k = 0; k < 6; k++)
         run_tile(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(7)), -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
